// File: rtl/uart_rx_peripheral_pkg.sv
// Shared definitions for the UART receive peripheral: FSM encoding, status bits, register map.
// Imported by the byte engine and the top-level message controller.
package uart_rx_peripheral_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_WRITE = 3'd4,
        ST_LEN   = 3'd5,
        ST_STAT  = 3'd6
    } state_t;

    localparam int STAT_DONE = 0;
    localparam int STAT_FERR = 1;
    localparam int STAT_OVF  = 2;

    localparam logic [7:0] DEF_REG_LEN_ADDR  = 8'h10;
    localparam logic [7:0] DEF_REG_STAT_ADDR = 8'h11;

    function automatic logic [7:0] stat_byte(input logic ovf, input logic ferr);
        logic [7:0] s;
        s            = '0;
        s[STAT_DONE] = 1'b1;
        s[STAT_FERR] = ferr;
        s[STAT_OVF]  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte engine: 2-flop synchroniser, start/data/stop sampling on a baud counter.
// Emits one-cycle byte/frame-error pulses; i_hold defers a new start edge until released.
module uart_rx_byte
    import uart_rx_peripheral_pkg::*;
#(
    parameter int BIT_CNT = 868
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i_rx,
    input  logic       i_en,
    input  logic       i_hold,
    output logic       o_busy,
    output logic       o_start,
    output logic       o_byte_vld,
    output logic [7:0] o_dat,
    output logic       o_frame_err,
    output logic       o_line
);

    localparam int CW = $clog2(BIT_CNT);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CNT - 1);

    logic [1:0]    r_sync;
    logic          r_line_d;
    logic          r_pend;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    logic w_line, w_fall, w_go, w_half, w_full;
    assign w_line = r_sync[1];
    assign w_fall = r_line_d & ~w_line;
    assign w_go   = ~i_hold & (r_pend | (w_fall & i_en));
    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], i_rx};
            r_line_d <= w_line;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_state_nxt = ST_START;
            ST_START: if (w_half) w_state_nxt = w_line ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_full && r_bit == 3'd7) w_state_nxt = ST_STOP;
            ST_STOP:  if (w_full) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_start     = 1'b0;
        o_byte_vld  = 1'b0;
        o_frame_err = 1'b0;
        case (r_state)
            ST_START: o_start = w_half & ~w_line;
            ST_STOP: begin
                o_byte_vld  = w_full & w_line;
                o_frame_err = w_full & ~w_line;
            end
            default: ;
        endcase
    end

    // An edge seen while the parent is reporting is remembered and started afterwards.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == ST_IDLE && !i_hold) r_pend <= 1'b0;
            else if (i_hold && w_fall && i_en) r_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                end
                ST_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                ST_DATA: begin
                    r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                    if (w_full) begin
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= {w_line, r_shift[7:1]};
                    end
                end
                ST_STOP: r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_dat  = r_shift;
    assign o_line = w_line;

endmodule

// File: rtl/uart_rx_peripheral.sv
// UART receive peripheral: stores received bytes into DPRAM and reports length/status on idle timeout.
// RAM write ~9.5 bit-times + 3 cycles after the start edge; no backpressure, one write per byte.
module uart_rx_peripheral
    import uart_rx_peripheral_pkg::*;
#(
    parameter int         CLK_FREQ      = 100000000,
    parameter int         BAUD          = 115200,
    parameter int         IDLE_BITS     = 16,
    parameter logic [7:0] REG_LEN_ADDR  = DEF_REG_LEN_ADDR,
    parameter logic [7:0] REG_STAT_ADDR = DEF_REG_STAT_ADDR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        uart_rx,
    input  logic        R_Recv_En,
    input  logic [7:0]  R_Ram_AddrH,
    input  logic [7:0]  R_Ram_AddrL,
    input  logic [7:0]  R_Recv_Max,
    output logic [14:0] RAM_Addr,
    output logic [7:0]  RAM_Write_Data,
    output logic        RAM_Write_En,
    output logic [7:0]  Reg_Addr,
    output logic [7:0]  Reg_Write_Data,
    output logic        Reg_Write_En,
    output logic        R_Rx_Busy
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int IDLE_TO = IDLE_BITS * BIT_CNT;
    localparam int TW      = $clog2(IDLE_TO + 1);
    localparam logic [TW-1:0] IDLE_TO_V = TW'(IDLE_TO);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [14:0]   r_base;
    logic [7:0]    r_max, r_idx, r_rcvd;
    logic          r_ovf, r_ferr, r_open;
    logic [TW-1:0] r_idle_cnt;

    logic       w_busy, w_start, w_byte_vld, w_frame_err, w_line, w_hold, w_timeout, w_store;
    logic [7:0] w_dat;

    assign w_hold    = (r_state == ST_LEN) || (r_state == ST_STAT);
    assign w_timeout = (r_idle_cnt == IDLE_TO_V) && ((r_rcvd != 8'd0) || r_ferr);
    assign w_store   = (r_idx < r_max);

    uart_rx_byte #(.BIT_CNT(BIT_CNT)) u_byte (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .i_rx        (uart_rx),
        .i_en        (R_Recv_En),
        .i_hold      (w_hold),
        .o_busy      (w_busy),
        .o_start     (w_start),
        .o_byte_vld  (w_byte_vld),
        .o_dat       (w_dat),
        .o_frame_err (w_frame_err),
        .o_line      (w_line)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_vld)     w_state_nxt = ST_WRITE;
                else if (w_timeout) w_state_nxt = ST_LEN;
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            ST_LEN:   w_state_nxt = ST_STAT;
            ST_STAT:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        RAM_Addr       = '0;
        RAM_Write_Data = '0;
        RAM_Write_En   = 1'b0;
        Reg_Addr       = '0;
        Reg_Write_Data = '0;
        Reg_Write_En   = 1'b0;
        case (r_state)
            ST_WRITE: if (w_store) begin
                RAM_Write_En   = 1'b1;
                RAM_Addr       = r_base + {7'd0, r_idx};
                RAM_Write_Data = w_dat;
            end
            ST_LEN: begin
                Reg_Write_En   = 1'b1;
                Reg_Addr       = REG_LEN_ADDR;
                Reg_Write_Data = r_idx;
            end
            ST_STAT: begin
                Reg_Write_En   = 1'b1;
                Reg_Addr       = REG_STAT_ADDR;
                Reg_Write_Data = stat_byte(r_ovf, r_ferr);
            end
            default: ;
        endcase
    end

    assign R_Rx_Busy = w_busy | r_open;

    // Base/max are latched on the first confirmed start bit so a glitch never opens a message.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_base     <= '0;
            r_max      <= '0;
            r_idx      <= '0;
            r_rcvd     <= '0;
            r_ovf      <= 1'b0;
            r_ferr     <= 1'b0;
            r_open     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (w_busy || !w_line)         r_idle_cnt <= '0;
            else if (r_idle_cnt != IDLE_TO_V) r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_start && !r_open) begin
                r_base <= {R_Ram_AddrH[6:0], R_Ram_AddrL};
                r_max  <= R_Recv_Max;
                r_open <= 1'b1;
            end
            if (w_frame_err) r_ferr <= 1'b1;

            case (r_state)
                ST_WRITE: begin
                    if (w_store) r_idx <= r_idx + 1'b1;
                    else         r_ovf <= 1'b1;
                    if (r_rcvd != 8'hFF) r_rcvd <= r_rcvd + 1'b1;
                end
                ST_STAT: begin
                    r_idx  <= '0;
                    r_rcvd <= '0;
                    r_ovf  <= 1'b0;
                    r_ferr <= 1'b0;
                    r_open <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Directed bench for uart_rx_peripheral at 16 clocks per bit (idle close after 256 cycles).
module tb_uart_rx_peripheral;

    localparam int BITC = 16;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        R_Recv_En = 1'b0;
    logic [7:0]  R_Ram_AddrH = 8'h00;
    logic [7:0]  R_Ram_AddrL = 8'h00;
    logic [7:0]  R_Recv_Max = 8'h00;
    logic [14:0] RAM_Addr;
    logic [7:0]  RAM_Write_Data;
    logic        RAM_Write_En;
    logic [7:0]  Reg_Addr;
    logic [7:0]  Reg_Write_Data;
    logic        Reg_Write_En;
    logic        R_Rx_Busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [22:0] ram_q[$];
    logic [15:0] reg_q[$];
    logic        clash = 1'b0;

    uart_rx_peripheral #(
        .CLK_FREQ  (100000000),
        .BAUD      (6250000),
        .IDLE_BITS (16)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .uart_rx        (uart_rx),
        .R_Recv_En      (R_Recv_En),
        .R_Ram_AddrH    (R_Ram_AddrH),
        .R_Ram_AddrL    (R_Ram_AddrL),
        .R_Recv_Max     (R_Recv_Max),
        .RAM_Addr       (RAM_Addr),
        .RAM_Write_Data (RAM_Write_Data),
        .RAM_Write_En   (RAM_Write_En),
        .Reg_Addr       (Reg_Addr),
        .Reg_Write_Data (Reg_Write_Data),
        .Reg_Write_En   (Reg_Write_En),
        .R_Rx_Busy      (R_Rx_Busy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (RAM_Write_En === 1'b1) ram_q.push_back({RAM_Addr, RAM_Write_Data});
        if (Reg_Write_En === 1'b1) reg_q.push_back({Reg_Addr, Reg_Write_Data});
        if (RAM_Write_En === 1'b1 && Reg_Write_En === 1'b1) clash = 1'b1;
    end

    task automatic drive_frame(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            uart_rx = frame[i];
            repeat (BITC) @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_frame({stop, b, 1'b0}, 10);
        uart_rx = 1'b1;
    endtask

    task automatic wait_regs(input int n, input string name);
        int k;
        k = 0;
        while (reg_q.size() < n && k < 1500) begin
            @(posedge Clk);
            k++;
        end
        #1;
        n_chk++;
        if (reg_q.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d register writes, need %0d", name, reg_q.size(), n);
        end
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic clear_q();
        ram_q.delete();
        reg_q.delete();
    endtask

    function automatic logic [22:0] ram_at(input int i);
        return (ram_q.size() > i) ? ram_q[i] : 23'bx;
    endfunction

    function automatic logic [15:0] reg_at(input int i);
        return (reg_q.size() > i) ? reg_q[i] : 16'bx;
    endfunction

    task automatic test_reset();
        logic [42:0] outs;
        repeat (3) @(posedge Clk);
        #1;
        outs = {RAM_Addr, RAM_Write_Data, RAM_Write_En, Reg_Addr, Reg_Write_Data, Reg_Write_En, R_Rx_Busy};
        n_chk++;
        if (outs !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, need 0", outs);
        end
        Rst_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_chk++;
        if (R_Rx_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, need 0", R_Rx_Busy);
        end
    endtask

    task automatic test_single();
        clear_q();
        R_Ram_AddrH = 8'h01; R_Ram_AddrL = 8'h00; R_Recv_Max = 8'd8; R_Recv_En = 1'b1;
        send_byte(8'h55, 1'b1);
        wait_regs(2, "single");
        n_chk++;
        if (ram_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d, need 1", ram_q.size()); end
        n_chk++;
        if (ram_at(0) !== {15'h0100, 8'h55}) begin n_fail++; $display("FAIL single_ram: got %h, need %h", ram_at(0), {15'h0100, 8'h55}); end
        n_chk++;
        if (reg_at(0) !== 16'h1001) begin n_fail++; $display("FAIL single_len: got %h, need 1001", reg_at(0)); end
        n_chk++;
        if (reg_at(1) !== 16'h1101) begin n_fail++; $display("FAIL single_stat: got %h, need 1101", reg_at(1)); end
        n_chk++;
        if (R_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, need 0", R_Rx_Busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'hAB;
        clear_q();
        for (int i = 0; i < 3; i++) send_byte(bytes[i], 1'b1);
        wait_regs(2, "b2b");
        n_chk++;
        if (ram_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d, need 3", ram_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (ram_at(i) !== {15'h0100 + 15'(i), bytes[i]}) begin
                n_fail++;
                $display("FAIL b2b_ram%0d: got %h, need %h", i, ram_at(i), {15'h0100 + 15'(i), bytes[i]});
            end
        end
        n_chk++;
        if (reg_at(0) !== 16'h1003) begin n_fail++; $display("FAIL b2b_len: got %h, need 1003", reg_at(0)); end
        n_chk++;
        if (reg_at(1) !== 16'h1101) begin n_fail++; $display("FAIL b2b_stat: got %h, need 1101", reg_at(1)); end
    endtask

    task automatic test_glitch();
        clear_q();
        uart_rx = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        n_chk++;
        if (R_Rx_Busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b, need 1", R_Rx_Busy); end
        uart_rx = 1'b1;
        repeat (400) @(posedge Clk);
        #1;
        n_chk++;
        if (ram_q.size() + reg_q.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_writes: got %0d writes, need 0", ram_q.size() + reg_q.size());
        end
        n_chk++;
        if (R_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b, need 0", R_Rx_Busy); end
    endtask

    task automatic test_frame_err();
        clear_q();
        send_byte(8'hC3, 1'b0);
        wait_regs(2, "ferr");
        n_chk++;
        if (ram_q.size() !== 0) begin n_fail++; $display("FAIL ferr_ram: got %0d writes, need 0", ram_q.size()); end
        n_chk++;
        if (reg_at(0) !== 16'h1000) begin n_fail++; $display("FAIL ferr_len: got %h, need 1000", reg_at(0)); end
        n_chk++;
        if (reg_at(1) !== 16'h1103) begin n_fail++; $display("FAIL ferr_stat: got %h, need 1103", reg_at(1)); end
    endtask

    task automatic test_overflow();
        clear_q();
        R_Recv_Max = 8'd2;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        wait_regs(2, "ovf");
        n_chk++;
        if (ram_q.size() !== 2) begin n_fail++; $display("FAIL ovf_count: got %0d, need 2", ram_q.size()); end
        n_chk++;
        if (ram_at(1) !== {15'h0101, 8'h02}) begin n_fail++; $display("FAIL ovf_ram1: got %h, need %h", ram_at(1), {15'h0101, 8'h02}); end
        n_chk++;
        if (reg_at(0) !== 16'h1002) begin n_fail++; $display("FAIL ovf_len: got %h, need 1002", reg_at(0)); end
        n_chk++;
        if (reg_at(1) !== 16'h1105) begin n_fail++; $display("FAIL ovf_stat: got %h, need 1105", reg_at(1)); end
    endtask

    task automatic test_wrap();
        clear_q();
        R_Ram_AddrH = 8'hFF; R_Ram_AddrL = 8'hFF; R_Recv_Max = 8'd8;
        send_byte(8'h9E, 1'b1);
        send_byte(8'h61, 1'b1);
        wait_regs(2, "wrap");
        n_chk++;
        if (ram_at(0) !== {15'h7FFF, 8'h9E}) begin n_fail++; $display("FAIL wrap_ram0: got %h, need %h", ram_at(0), {15'h7FFF, 8'h9E}); end
        n_chk++;
        if (ram_at(1) !== {15'h0000, 8'h61}) begin n_fail++; $display("FAIL wrap_ram1: got %h, need %h", ram_at(1), {15'h0000, 8'h61}); end
        n_chk++;
        if (reg_at(0) !== 16'h1002) begin n_fail++; $display("FAIL wrap_len: got %h, need 1002", reg_at(0)); end
    endtask

    task automatic test_disabled();
        clear_q();
        R_Recv_En = 1'b0;
        send_byte(8'h3C, 1'b1);
        repeat (400) @(posedge Clk);
        #1;
        n_chk++;
        if (ram_q.size() + reg_q.size() !== 0) begin
            n_fail++;
            $display("FAIL disabled_writes: got %0d writes, need 0", ram_q.size() + reg_q.size());
        end
        R_Recv_En = 1'b1;
    endtask

    task automatic test_reset_midframe();
        clear_q();
        R_Ram_AddrH = 8'h02; R_Ram_AddrL = 8'h40;
        drive_frame({1'b1, 8'hFF, 1'b0}, 5);
        uart_rx = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        n_chk++;
        if (R_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, need 0", R_Rx_Busy); end
        Rst_n = 1'b1;
        repeat (40) @(posedge Clk);
        #1;
        send_byte(8'hA5, 1'b1);
        wait_regs(2, "rst_mid");
        n_chk++;
        if (ram_q.size() !== 1) begin n_fail++; $display("FAIL rst_mid_count: got %0d, need 1", ram_q.size()); end
        n_chk++;
        if (ram_at(0) !== {15'h0240, 8'hA5}) begin n_fail++; $display("FAIL rst_mid_ram: got %h, need %h", ram_at(0), {15'h0240, 8'hA5}); end
        n_chk++;
        if (reg_at(0) !== 16'h1001) begin n_fail++; $display("FAIL rst_mid_len: got %h, need 1001", reg_at(0)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_wrap();
        test_disabled();
        test_reset_midframe();
        n_chk++;
        if (clash !== 1'b0) begin n_fail++; $display("FAIL write_clash: got %b, need 0", clash); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
